analog_core_array_ctrl: RTL and testbench

// Digital companion for an array of N_CH analog filter cores (I/Q interleaved).

---
 rtl/analog_core_array_ctrl.sv | 164 ++++++++++++++++
 tb/tb_analog_core_array_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_core_array_ctrl.sv
// analog_core_array_ctrl: cclk/div2/LO generation, comparator->fb1 loop and timestamped event FIFO.
// Define ANALOG_CTRL_FB_OVERRIDE_EN to add fb_ovr_en/fb_ovr_val forcing of fb1.
module analog_core_array_ctrl #(
    parameter int N_CH       = 4,
    parameter int DIV_W      = 8,
    parameter int TS_W       = 12,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int EV_W      = CH_W + 1 + TS_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [N_CH-1:0]  high_buf,
    input  logic [N_CH-1:0]  phi1b_dig,
    output logic             cclk,
    output logic             div2,
    output logic [N_CH-1:0]  lo,
    output logic [N_CH-1:0]  fb1,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [EV_W-1:0]  ev_data,
    output logic             ovf,
    input  logic             clr_ovf
`ifdef ANALOG_CTRL_FB_OVERRIDE_EN
    ,
    input  logic             fb_ovr_en,
    input  logic [N_CH-1:0]  fb_ovr_val
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             cclk_q, cclk_d, div2_q, div2_d;
    logic [1:0]       j_q, j_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [N_CH-1:0]  hb_s1_q, hb_s2_q, ph_s1_q, ph_s2_q, ph_s3_q;
    logic [N_CH-1:0]  fb_q, fb_d, pend_q, pend_d, hval_q, hval_d;
    logic [N_CH-1:0]  sel, gnt, chg;
    logic [TS_W-1:0]  hts_q [N_CH];
    logic [TS_W-1:0]  hts_d [N_CH];
    logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
    logic [EV_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      fcnt_q, fcnt_d;
    logic             ev_valid_q, ev_valid_d, ovf_q, ovf_d;
    logic [EV_W-1:0]  ev_data_q, ev_data_d, push_data;
    logic [CH_W-1:0]  gch;
    logic             tick, rise, push, pop, lost;

    always_comb begin
        tick   = en && (cnt_q >= div_cfg);
        rise   = tick && !cclk_q;
        cnt_d  = !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
        cclk_d = cclk_q ^ tick;
        div2_d = div2_q ^ rise;
        j_d    = rise ? {j_q[0], ~j_q[1]} : j_q;
        ts_d   = ts_q + TS_W'(rise);
    end

    // Channels are scanned high to low so the lowest pending index wins the FIFO slot.
    always_comb begin
        chg    = '0;
        sel    = '0;
        gch    = '0;
        fb_d   = fb_q;
        hval_d = hval_q;
        hts_d  = hts_q;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en && ph_s2_q[i] && !ph_s3_q[i]) begin
                fb_d[i] = hb_s2_q[i];
                chg[i]  = hb_s2_q[i] != fb_q[i];
            end
            if (chg[i]) begin
                hval_d[i] = hb_s2_q[i];
                hts_d[i]  = ts_q;
            end
            if (pend_q[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                gch    = CH_W'(i);
            end
        end
        pop        = ev_valid_q && ev_ready;
        push       = |pend_q && (fcnt_q != (PW+1)'(FIFO_DEPTH) || pop);
        gnt        = push ? sel : '0;
        lost       = |(chg & pend_q & ~gnt);
        pend_d     = (pend_q & ~gnt) | chg;
        ovf_d      = lost || (ovf_q && !clr_ovf);
        push_data  = {gch, hval_q[gch], hts_q[gch]};
        mem_d      = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d       = wr_q + PW'(push);
        rd_d       = rd_q + PW'(pop);
        fcnt_d     = fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
        ev_valid_d = fcnt_d != '0;
        ev_data_d  = ev_valid_d ? mem_d[rd_d] : ev_data_q;
    end

    always_comb begin
        lo = '0;
        for (int i = 0; i < N_CH; i++) lo[i] = (i % 2 == 0) ? j_q[0] : j_q[1];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q      <= '0;
            cclk_q     <= 1'b0;
            div2_q     <= 1'b0;
            j_q        <= 2'b00;
            ts_q       <= '0;
            hb_s1_q    <= '0;
            hb_s2_q    <= '0;
            ph_s1_q    <= '0;
            ph_s2_q    <= '0;
            ph_s3_q    <= '0;
            fb_q       <= '0;
            pend_q     <= '0;
            hval_q     <= '0;
            hts_q      <= '{default: '0};
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            fcnt_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cclk_q     <= cclk_d;
            div2_q     <= div2_d;
            j_q        <= j_d;
            ts_q       <= ts_d;
            hb_s1_q    <= high_buf;
            hb_s2_q    <= hb_s1_q;
            ph_s1_q    <= phi1b_dig;
            ph_s2_q    <= ph_s1_q;
            ph_s3_q    <= ph_s2_q;
            fb_q       <= fb_d;
            pend_q     <= pend_d;
            hval_q     <= hval_d;
            hts_q      <= hts_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fcnt_q     <= fcnt_d;
            ev_valid_q <= ev_valid_d;
            ev_data_q  <= ev_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cclk     = cclk_q;
    assign div2     = div2_q;
    assign ev_valid = ev_valid_q;
    assign ev_data  = ev_data_q;
    assign ovf      = ovf_q;
`ifdef ANALOG_CTRL_FB_OVERRIDE_EN
    assign fb1 = fb_ovr_en ? fb_ovr_val : fb_q;
`else
    assign fb1 = fb_q;
`endif
endmodule

// File: tb/tb_analog_core_array_ctrl.sv
// tb_analog_core_array_ctrl: random comparator strobes against an arithmetic clock/timestamp model,
// expected events queued at stimulus time and popped by a monitor on each accepted handshake.
module tb_analog_core_array_ctrl;
    localparam int N_CH = 4, DIV_W = 8, TS_W = 12, FIFO_DEPTH = 8, CH_W = 2;
    localparam int EV_W = CH_W + 1 + TS_W;

    logic             wb_clk_i = 1'b0, wb_rst_i = 1'b1, en = 1'b0, ev_ready = 1'b0, clr_ovf = 1'b0;
    logic [DIV_W-1:0] div_cfg = 8'd3;
    logic [N_CH-1:0]  high_buf = '0, phi1b_dig = '0;
    logic             cclk, div2, ev_valid, ovf;
    logic [N_CH-1:0]  lo, fb1;
    logic [EV_W-1:0]  ev_data;
`ifdef ANALOG_CTRL_FB_OVERRIDE_EN
    logic             fb_ovr_en = 1'b0;
    logic [N_CH-1:0]  fb_ovr_val = '0;
`endif

    int n_chk = 0, n_pass = 0, n_en = 0, mdiv = 3, rdy_mode = 0, held_cnt = 0;
    bit clk_chk = 0, hold = 0, exp_ovf = 0;
    logic [EV_W-1:0] q[$];
    logic [EV_W-1:0] slot [N_CH];
    bit              slot_v [N_CH];
    logic [N_CH-1:0] m_fb = '0;

    analog_core_array_ctrl dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .en(en), .div_cfg(div_cfg),
        .high_buf(high_buf), .phi1b_dig(phi1b_dig), .cclk(cclk), .div2(div2), .lo(lo),
        .fb1(fb1), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef ANALOG_CTRL_FB_OVERRIDE_EN
        , .fb_ovr_en(fb_ovr_en), .fb_ovr_val(fb_ovr_val)
`endif
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Enabled wb_clk_i edges since reset; the whole clock model is derived from this count.
    always @(posedge wb_clk_i) n_en <= wb_rst_i ? 0 : n_en + (en ? 1 : 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int toggles(int n);
        return n / (mdiv + 1);
    endfunction

    function automatic logic [TS_W-1:0] ts_of(int n);
        return TS_W'((toggles(n) + 1) / 2);
    endfunction

    function automatic logic [N_CH-1:0] lo_of(int ts);
        logic [N_CH-1:0] r;
        int ph;
        ph = ts % 4;
        for (int k = 0; k < N_CH; k++) r[k] = (k % 2 == 0) ? (ph == 1 || ph == 2) : (ph == 2 || ph == 3);
        return r;
    endfunction

    function automatic logic [N_CH-1:0] fb_exp();
`ifdef ANALOG_CTRL_FB_OVERRIDE_EN
        return fb_ovr_en ? fb_ovr_val : m_fb;
`else
        return m_fb;
`endif
    endfunction

    always @(negedge wb_clk_i) begin
        if (clk_chk) begin
            check("cclk", cclk, toggles(n_en) % 2);
            check("div2", div2, ((toggles(n_en) + 1) / 2) % 2);
            check("lo", lo, lo_of((toggles(n_en) + 1) / 2));
        end
    end

    always @(negedge wb_clk_i) begin
        ev_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(3) != 0);
        if (!wb_rst_i && ev_valid && ev_ready) begin
            if (q.size() == 0) check("spurious_ev_valid", ev_valid, 1'b0);
            else check("ev_data", ev_data, q.pop_front());
        end
    end

    task automatic sb_push(input int ch, input logic v, input logic [TS_W-1:0] ts);
        logic [EV_W-1:0] e;
        e = {CH_W'(ch), v, ts};
        if (hold && held_cnt >= FIFO_DEPTH) begin
            if (slot_v[ch]) exp_ovf = 1;
            slot[ch]   = e;
            slot_v[ch] = 1;
        end else begin
            q.push_back(e);
            if (hold) held_cnt++;
        end
    endtask

    task automatic release_hold();
        for (int k = 0; k < N_CH; k++) if (slot_v[k]) begin
            q.push_back(slot[k]);
            slot_v[k] = 0;
        end
        hold     = 0;
        held_cnt = 0;
    endtask

    task automatic strobe(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] vals);
        int base;
        @(negedge wb_clk_i);
        high_buf = (high_buf & ~mask) | (vals & mask);
        repeat (3) @(negedge wb_clk_i);
        phi1b_dig = mask;
        base      = n_en;
        @(negedge wb_clk_i);
        phi1b_dig = '0;
        for (int i = 0; i < N_CH; i++) if (en && mask[i] && vals[i] != m_fb[i]) begin
            sb_push(i, vals[i], ts_of(base + 2));
            m_fb[i] = vals[i];
        end
        repeat (2) @(negedge wb_clk_i);
        check("fb1", fb1, fb_exp());
        repeat (3) @(negedge wb_clk_i);
    endtask

    task automatic drain();
        int k;
        k = 0;
        rdy_mode = 2;
        while (q.size() != 0 && k < 400) begin
            @(negedge wb_clk_i);
            k++;
        end
        check("drain_queue_left", q.size(), 0);
        repeat (3) @(negedge wb_clk_i);
        check("ev_valid_idle", ev_valid, 1'b0);
    endtask

    task automatic do_reset(input int dv);
        @(negedge wb_clk_i);
        rdy_mode = 0;
        @(negedge wb_clk_i);
        clk_chk  = 0;
        wb_rst_i = 1;
        en       = 0;
        repeat (2) @(negedge wb_clk_i);
        check("rst_cclk", cclk, 1'b0);
        check("rst_div2", div2, 1'b0);
        check("rst_lo", lo, '0);
        check("rst_fb1", fb1, '0);
        check("rst_ev_valid", ev_valid, 1'b0);
        check("rst_ev_data", ev_data, '0);
        check("rst_ovf", ovf, 1'b0);
        q.delete();
        for (int k = 0; k < N_CH; k++) slot_v[k] = 0;
        m_fb     = '0;
        held_cnt = 0;
        hold     = 0;
        exp_ovf  = 0;
        div_cfg  = DIV_W'(dv);
        mdiv     = dv;
        wb_rst_i = 0;
    endtask

    initial begin
        for (int k = 0; k < N_CH; k++) slot_v[k] = 0;
        do_reset(3);
        en = 1; clk_chk = 1; rdy_mode = 1;
        strobe(4'b0100, 4'b0100);
        strobe(4'b1001, 4'b1001);
        repeat (6) @(negedge wb_clk_i);
        check("ovf_simultaneous", ovf, 1'b0);
        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                do_reset(r == 1 ? 0 : int'($urandom_range(6, 1)));
                clk_chk = 1;
            end
            rdy_mode = 2;
            for (int s = 0; s < 25; s++) begin
                en = $urandom_range(5) != 0;
                strobe(N_CH'($urandom), N_CH'($urandom));
            end
            en = 1;
            drain();
            check("ovf_random", ovf, 1'b0);
        end
        do_reset(1);
        en = 1; clk_chk = 1; hold = 1;
        for (int s = 0; s < 10; s++) strobe(4'b0010, ~m_fb);
        check("ev_valid_full", ev_valid, 1'b1);
        check("ovf_set", ovf, exp_ovf);
        @(negedge wb_clk_i);
        clr_ovf = 1;
        @(negedge wb_clk_i);
        clr_ovf = 0;
        check("ovf_cleared", ovf, 1'b0);
        release_hold();
        drain();
        hold = 1; rdy_mode = 0;
        for (int s = 0; s < 3; s++) strobe(4'b1111, ~m_fb);
        check("ev_valid_before_rst", ev_valid, 1'b1);
        do_reset(10);
        rdy_mode = 1; en = 1;
        repeat (7) @(negedge wb_clk_i);
        check("t5_cclk_cnt7", cclk, 1'b0);
        div_cfg = 8'd2;
        @(negedge wb_clk_i);
        check("t5_cclk_wrap", cclk, 1'b1);
        repeat (2) @(negedge wb_clk_i);
        check("t5_cclk_hold", cclk, 1'b1);
        @(negedge wb_clk_i);
        check("t5_cclk_fall", cclk, 1'b0);
        en = 0;
        repeat (10) @(negedge wb_clk_i);
        check("t5_frozen_cclk", cclk, 1'b0);
        check("t5_frozen_div2", div2, 1'b1);
        en = 1;
        repeat (2) @(negedge wb_clk_i);
        check("t5_resume_cclk_low", cclk, 1'b0);
        @(negedge wb_clk_i);
        check("t5_resume_cclk", cclk, 1'b1);
        check("t5_resume_div2", div2, 1'b0);
`ifdef ANALOG_CTRL_FB_OVERRIDE_EN
        do_reset(2);
        en = 1; clk_chk = 1; rdy_mode = 1;
        fb_ovr_val = 4'b1010;
        fb_ovr_en  = 1;
        @(negedge wb_clk_i);
        check("fb1_override", fb1, 4'b1010);
        strobe(4'b0101, 4'b0101);
        fb_ovr_en = 0;
        #1;
        check("fb1_internal", fb1, m_fb);
        drain();
`endif
        repeat (5) @(negedge wb_clk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
